// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Round-robin arbiter sharing the single L2 cache port between the L1
//   instruction cache (l1i_*) and the L1 data cache (l1d_*). A grant is held
//   for one full block transfer; word data is forwarded combinationally
//   between the owner and the L2. Ties are counted in a saturating counter.
//
// Ports
//   clock_i, reset_i          : single clock, synchronous active-high reset
//   l1{i,d}_req_i/rw_i/add_i  : block request, direction, block address
//   l1{i,d}_data_i            : write data word (advances after each valid_o)
//   l1{i,d}_data_o/valid_o    : read data / word strobe to the owner
//   l1{i,d}_done_o            : one-cycle transfer-complete pulse
//   l2_req_o/rw_o/add_o       : request, direction and address to the L2
//   l2_data_o                 : write data to the L2
//   l2_ready_i/valid_i/data_i : L2 accept, per-word strobe, read data
//   grant_o                   : one-hot owner {d,i}, 00 when idle
//   busy_o                    : arbiter not idle
//   conflict_cnt_o            : saturating count of tie arbitrations
module l2_port_arbiter #(
  parameter int BW_ADDR     = 24,
  parameter int BLOCK_WORDS = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               l1i_req_i,
  input  logic               l1i_rw_i,
  input  logic [BW_ADDR-1:0] l1i_add_i,
  input  logic [31:0]        l1i_data_i,
  output logic [31:0]        l1i_data_o,
  output logic               l1i_valid_o,
  output logic               l1i_done_o,
  input  logic               l1d_req_i,
  input  logic               l1d_rw_i,
  input  logic [BW_ADDR-1:0] l1d_add_i,
  input  logic [31:0]        l1d_data_i,
  output logic [31:0]        l1d_data_o,
  output logic               l1d_valid_o,
  output logic               l1d_done_o,
  output logic               l2_req_o,
  output logic               l2_rw_o,
  output logic [BW_ADDR-1:0] l2_add_o,
  output logic [31:0]        l2_data_o,
  input  logic               l2_ready_i,
  input  logic               l2_valid_i,
  input  logic [31:0]        l2_data_i,
  output logic [1:0]         grant_o,
  output logic               busy_o,
  output logic [15:0]        conflict_cnt_o
);

  // One extra bit so the counter can actually hold BLOCK_WORDS.
  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;          // 0 = L1I, 1 = L1D
  logic               last_grant_q, last_grant_d;
  logic               rw_q, rw_d;
  logic [BW_ADDR-1:0] add_q, add_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        conflict_q, conflict_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      rw_q         <= 1'b0;
      add_q        <= '0;
      cnt_q        <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      add_q        <= add_d;
      cnt_q        <= cnt_d;
      conflict_q   <= conflict_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rw_d         = rw_q;
    add_d        = add_q;
    cnt_d        = cnt_q;
    conflict_d   = conflict_q;
    case (state_q)
      S_IDLE: begin
        if (l1i_req_i || l1d_req_i) begin
          if (l1i_req_i && l1d_req_i) begin
            // Tie: the side that did not win last time gets the port.
            owner_d = ~last_grant_q;
            if (conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
          end else begin
            owner_d = l1d_req_i;
          end
          rw_d         = owner_d ? l1d_rw_i  : l1i_rw_i;
          add_d        = owner_d ? l1d_add_i : l1i_add_i;
          last_grant_d = owner_d;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        // Strobes from the L2 before it has accepted the request are noise.
        if (l2_ready_i) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (l2_valid_i) cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(BLOCK_WORDS)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;  // S_DONE: single-cycle completion
    endcase
  end

  // Output steering: only the owner ever sees a strobe, data or done.
  always_comb begin
    l1i_data_o  = '0;
    l1i_valid_o = 1'b0;
    l1i_done_o  = 1'b0;
    l1d_data_o  = '0;
    l1d_valid_o = 1'b0;
    l1d_done_o  = 1'b0;
    l2_data_o   = '0;
    l2_req_o    = (state_q == S_REQ);
    busy_o      = (state_q != S_IDLE);
    grant_o     = busy_o ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    if (state_q == S_XFER) begin
      if (owner_q) begin
        l1d_valid_o = l2_valid_i;
        if (rw_q) l2_data_o  = l1d_data_i;
        else      l1d_data_o = l2_data_i;
      end else begin
        l1i_valid_o = l2_valid_i;
        if (rw_q) l2_data_o  = l1i_data_i;
        else      l1i_data_o = l2_data_i;
      end
    end
    if (state_q == S_DONE) begin
      l1i_done_o = ~owner_q;
      l1d_done_o = owner_q;
    end
  end

  assign l2_rw_o        = rw_q;
  assign l2_add_o       = add_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
`timescale 1ns/1ps
module tb_l2_port_arbiter;

  localparam int BW = 24;
  localparam int NW = 16;

  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_RD    = 2'd1;
  localparam logic [1:0] K_WR    = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        port;   // 0 = L1I, 1 = L1D
    logic        rw;
    logic [31:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          l1i_req_i, l1i_rw_i, l1d_req_i, l1d_rw_i;
  logic [BW-1:0] l1i_add_i, l1d_add_i;
  logic [31:0]   l1i_data_i, l1d_data_i, l1i_data_o, l1d_data_o;
  logic          l1i_valid_o, l1i_done_o, l1d_valid_o, l1d_done_o;
  logic          l2_req_o, l2_rw_o, l2_ready_i, l2_valid_i, busy_o;
  logic [BW-1:0] l2_add_o;
  logic [31:0]   l2_data_o, l2_data_i;
  logic [1:0]    grant_o;
  logic [15:0]   conflict_cnt_o;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  last_valid_cyc = 0;
  int  lat;
  logic prev_req = 1'b0;
  ev_t exp_q[$];

  l2_port_arbiter #(.BW_ADDR(BW), .BLOCK_WORDS(NW)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .l1i_req_i(l1i_req_i), .l1i_rw_i(l1i_rw_i), .l1i_add_i(l1i_add_i),
    .l1i_data_i(l1i_data_i), .l1i_data_o(l1i_data_o),
    .l1i_valid_o(l1i_valid_o), .l1i_done_o(l1i_done_o),
    .l1d_req_i(l1d_req_i), .l1d_rw_i(l1d_rw_i), .l1d_add_i(l1d_add_i),
    .l1d_data_i(l1d_data_i), .l1d_data_o(l1d_data_o),
    .l1d_valid_o(l1d_valid_o), .l1d_done_o(l1d_done_o),
    .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o), .l2_add_o(l2_add_o),
    .l2_data_o(l2_data_o), .l2_ready_i(l2_ready_i), .l2_valid_i(l2_valid_i),
    .l2_data_i(l2_data_i), .grant_o(grant_o), .busy_o(busy_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("[TB] ok %s: %h (cycle %0d)", name, act, cyc);
  endtask

  function automatic bit pop_ev(input string name, output ev_t e);
    e = '0;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_%s: got event expected none (cycle %0d)", name, cyc);
      return 1'b0;
    end
    e = exp_q.pop_front();
    return 1'b1;
  endfunction

  // Expected events of one complete transfer: grant, NW words, done.
  task automatic push_xfer(input logic port, input logic rw, input logic [BW-1:0] addr,
                           input logic [31:0] base, input int nwords, input bit with_done);
    exp_q.push_back('{kind: K_GRANT, port: port, rw: rw, data: 32'(addr)});
    for (int w = 0; w < nwords; w++)
      exp_q.push_back('{kind: rw ? K_WR : K_RD, port: port, rw: rw, data: base + 32'(w)});
    if (with_done) exp_q.push_back('{kind: K_DONE, port: port, rw: rw, data: 32'd1});
  endtask

  task automatic raise(input logic port, input logic rw, input logic [BW-1:0] addr);
    if (port) begin l1d_req_i = 1'b1; l1d_rw_i = rw; l1d_add_i = addr; end
    else      begin l1i_req_i = 1'b1; l1i_rw_i = rw; l1i_add_i = addr; end
  endtask

  // L2 model: waits for a request, optionally strobes valid early, accepts,
  // then delivers nwords strobes separated by gap idle cycles.
  task automatic serve(input int gap, input int early, input int nwords,
                       input logic [31:0] base, output int waited);
    bit seen = 1'b0;
    waited = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      waited++;
      if (l2_req_o) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL serve_timeout: got no l2_req_o expected request within 200 cycles");
      return;
    end
    repeat (early) begin
      l2_valid_i = 1'b1; l2_data_i = 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end
    l2_valid_i = 1'b0;
    l2_ready_i = 1'b1;
    @(posedge clk); #1;
    l2_ready_i = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      repeat (gap) begin @(posedge clk); #1; end
      l2_data_i  = base + 32'(w);
      l1i_data_i = base + 32'(w);
      l1d_data_i = base + 32'(w);
      l2_valid_i = 1'b1;
      @(posedge clk); #1;
      l2_valid_i = 1'b0;
    end
  endtask

  // Requesters drop req in the cycle after their done pulse.
  initial forever begin
    @(negedge clk);
    if (l1i_done_o) begin @(posedge clk); #1; l1i_req_i = 1'b0; end
  end
  initial forever begin
    @(negedge clk);
    if (l1d_done_o) begin @(posedge clk); #1; l1d_req_i = 1'b0; end
  end

  // Monitor: pops expected events whenever the DUT presents one.
  initial begin : monitor
    ev_t e, a;
    logic p;
    forever begin
      @(negedge clk);
      if (reset_i) prev_req = 1'b0;
      else begin
        if (l2_req_o && !prev_req && pop_ev("grant", e)) begin
          a.kind = K_GRANT; a.rw = l2_rw_o; a.data = 32'(l2_add_o);
          a.port = (grant_o == 2'b10) ? 1'b1 : (grant_o == 2'b01) ? 1'b0 : ~e.port;
          check("grant", 64'(a), 64'(e));
        end
        prev_req = l2_req_o;
        if (l1i_valid_o && l1d_valid_o) begin
          tests++; fails++;
          $display("FAIL both_valid: got 11 expected one-hot strobe");
        end else if ((l1i_valid_o || l1d_valid_o) && pop_ev("word", e)) begin
          p = l1d_valid_o;
          a.kind = l2_rw_o ? K_WR : K_RD; a.port = p; a.rw = l2_rw_o;
          a.data = l2_rw_o ? l2_data_o : (p ? l1d_data_o : l1i_data_o);
          check("word", 64'(a), 64'(e));
          // Non-owner side silent; l2_data_o idle on reads.
          check("gate", p ? 64'({l1i_valid_o, l1i_done_o, l1i_data_o})
                          : 64'({l1d_valid_o, l1d_done_o, l1d_data_o}), 64'd0);
          if (!l2_rw_o) check("l2_data_rd", 64'(l2_data_o), 64'd0);
          last_valid_cyc = cyc;
        end
        if (l1i_done_o && l1d_done_o) begin
          tests++; fails++;
          $display("FAIL both_done: got 11 expected one-hot done");
        end else if ((l1i_done_o || l1d_done_o) && pop_ev("done", e)) begin
          a.kind = K_DONE; a.port = l1d_done_o; a.rw = l2_rw_o;
          a.data = 32'(cyc - last_valid_cyc);
          check("done", 64'(a), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_i = 1'b1;
    l1i_req_i = 0; l1i_rw_i = 0; l1i_add_i = '0; l1i_data_i = '0;
    l1d_req_i = 0; l1d_rw_i = 0; l1d_add_i = '0; l1d_data_i = '0;
    l2_ready_i = 0; l2_valid_i = 0; l2_data_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_busy",     64'(busy_o),   64'd0);
    check("rst_grant",    64'(grant_o),  64'd0);
    check("rst_l2_req",   64'(l2_req_o), 64'd0);
    check("rst_l2_add",   64'({l2_rw_o, l2_add_o}), 64'd0);
    check("rst_conflict", 64'(conflict_cnt_o), 64'd0);
    check("rst_l1_outs",  64'({l1i_valid_o, l1i_done_o, l1d_valid_o, l1d_done_o}), 64'd0);
    @(posedge clk); #1;

    // Single L1I read, ready at t+1, contiguous valids 0..15.
    push_xfer(1'b0, 1'b0, 24'h000100, 32'd0, NW, 1'b1);
    raise(1'b0, 1'b0, 24'h000100);
    serve(0, 0, NW, 32'd0, lat);
    check("req_latency", 64'(lat), 64'd2);
    repeat (3) @(posedge clk); #1;

    // Tie after reset: L1D first, then L1I; a further tie goes to L1D.
    push_xfer(1'b1, 1'b0, 24'h000300, 32'h300, NW, 1'b1);
    push_xfer(1'b0, 1'b0, 24'h000400, 32'h400, NW, 1'b1);
    raise(1'b1, 1'b0, 24'h000300); raise(1'b0, 1'b0, 24'h000400);
    serve(0, 0, NW, 32'h300, lat);
    check("tie1_conflict", 64'(conflict_cnt_o), 64'd1);
    serve(0, 0, NW, 32'h400, lat);
    repeat (3) @(posedge clk); #1;
    push_xfer(1'b1, 1'b0, 24'h000500, 32'h500, NW, 1'b1);
    push_xfer(1'b0, 1'b0, 24'h000600, 32'h600, NW, 1'b1);
    raise(1'b1, 1'b0, 24'h000500); raise(1'b0, 1'b0, 24'h000600);
    serve(0, 0, NW, 32'h500, lat);
    check("tie2_conflict", 64'(conflict_cnt_o), 64'd2);
    serve(0, 0, NW, 32'h600, lat);
    repeat (3) @(posedge clk); #1;

    // L1D writeback with 2-cycle gaps, data 0xA0..0xAF.
    push_xfer(1'b1, 1'b1, 24'h000200, 32'hA0, NW, 1'b1);
    raise(1'b1, 1'b1, 24'h000200);
    serve(2, 0, NW, 32'hA0, lat);
    repeat (3) @(posedge clk); #1;
    check("wr_conflict", 64'(conflict_cnt_o), 64'd2);

    // Early valids during REQ must be ignored.
    push_xfer(1'b0, 1'b0, 24'h000700, 32'h700, NW, 1'b1);
    raise(1'b0, 1'b0, 24'h000700);
    serve(0, 2, NW, 32'h700, lat);
    repeat (3) @(posedge clk); #1;

    // Reset after 7 words of an L1I read: no done, everything cleared.
    push_xfer(1'b0, 1'b0, 24'h000800, 32'h800, 7, 1'b0);
    raise(1'b0, 1'b0, 24'h000800);
    serve(0, 0, 7, 32'h800, lat);
    reset_i = 1'b1; l1i_req_i = 1'b0; l1d_req_i = 1'b0;
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  64'({busy_o, grant_o, l2_req_o}), 64'd0);
    check("mid_rst_outs",  64'({l1i_valid_o, l1i_done_o, l1d_valid_o, l1d_done_o,
                                l1i_data_o, l1d_data_o, l2_data_o}), 64'd0);
    check("mid_rst_l2",    64'({l2_rw_o, l2_add_o}), 64'd0);
    check("mid_rst_count", 64'(conflict_cnt_o), 64'd0);
    @(posedge clk); #1;
    push_xfer(1'b1, 1'b0, 24'h000900, 32'h900, NW, 1'b1);
    push_xfer(1'b0, 1'b0, 24'h000A00, 32'hA00, NW, 1'b1);
    raise(1'b1, 1'b0, 24'h000900); raise(1'b0, 1'b0, 24'h000A00);
    serve(0, 0, NW, 32'h900, lat);
    check("post_rst_conflict", 64'(conflict_cnt_o), 64'd1);
    serve(0, 0, NW, 32'hA00, lat);
    repeat (3) @(posedge clk); #1;

    // Saturation: preload near the top instead of 65536 real ties.
    force dut.conflict_q = 16'hFFFE;
    repeat (2) @(posedge clk);
    #1 release dut.conflict_q;
    @(negedge clk);
    check("sat_preload", 64'(conflict_cnt_o), 64'hFFFE);
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      push_xfer(1'b1, 1'b0, 24'h000B00, 32'hB00, NW, 1'b1);
      push_xfer(1'b0, 1'b0, 24'h000C00, 32'hC00, NW, 1'b1);
      raise(1'b1, 1'b0, 24'h000B00); raise(1'b0, 1'b0, 24'h000C00);
      serve(0, 0, NW, 32'hB00, lat);
      check("sat_conflict", 64'(conflict_cnt_o), 64'hFFFF);
      serve(0, 0, NW, 32'hC00, lat);
      repeat (3) @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
